// File: rtl/mem_dumper_pkg.sv
// Shared definitions for the memory dumper: FSM states and UART framing.
package mem_dumper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    WAIT,
    FINISH
  } state_t;

  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
  localparam int FRAME_BITS           = 1 + DATA_BITS + STOP_BITS;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/mem_dumper_uart_tx.sv
// 8N1 UART transmitter, LSB first. tx_busy rises the cycle after tx_start
// and falls once the stop bit has been on the line for CLKS_PER_BIT cycles.
module uart_tx
  import mem_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  // Bits still to be sent after the one on the line; the stop bit sits on top
  logic [DATA_BITS:0]   shift;

  // Bit timer and shift register; the line is driven straight from a flop
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '1;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx      <= 1'b0;
        shift   <= {1'b1, tx_data};
        clk_cnt <= '0;
        bit_cnt <= '0;
      end
    end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
      if (bit_cnt == BW'(FRAME_BITS - 1)) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        tx      <= shift[0];
        shift   <= {1'b1, shift[DATA_BITS:1]};
      end
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_dumper.sv
// Reads len bytes starting at base_adr and streams them out over the UART.
// adr always shows the current read address so the external bus never glitches.
module mem_dumper
  import mem_dumper_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int READ_CYCLES  = 2,
  parameter int ADR_W        = 21
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic [ADR_W-1:0]     base_adr,
  input  logic [ADR_W-1:0]     len,
  output logic [ADR_W-1:0]     adr,
  output logic                 read,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int RCW = $clog2(READ_CYCLES + 1);

  state_t               state;
  logic [ADR_W-1:0]     remaining;
  logic [RCW-1:0]       rd_cnt;
  logic [DATA_BITS-1:0] byte_q;
  logic                 tx_start;
  logic                 tx_busy;

  // Dump sequencer: all bus and handshake outputs are registered here.
  // The cycle after FINISH is spent in IDLE with busy still high so that the
  // done pulse and the busy drop land one cycle apart; start is ignored then.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      adr       <= '0;
      remaining <= '0;
      rd_cnt    <= '0;
      byte_q    <= '0;
      read      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_start  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !busy) begin
            adr       <= base_adr;
            remaining <= len;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= FINISH;
            end else begin
              state  <= READ;
              read   <= 1'b1;
              rd_cnt <= '0;
            end
          end
        end
        READ: begin
          if (rd_cnt == RCW'(READ_CYCLES - 1)) begin
            byte_q   <= data;
            read     <= 1'b0;
            tx_start <= 1'b1;
            state    <= SEND;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        SEND: begin
          tx_start  <= 1'b0;
          adr       <= adr + 1'b1;
          remaining <= remaining - 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (!tx_busy) begin
            if (remaining != '0) begin
              state  <= READ;
              read   <= 1'b1;
              rd_cnt <= '0;
            end else begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .n_reset (n_reset),
    .tx_start(tx_start),
    .tx_data (byte_q),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

endmodule
